// File: rtl/myla_drain_if.sv
// Wishbone classic bus between the myla_drain initiator and the analyzer's register port.
// The master modport is the initiator side; the slave modport is the responder side.
interface myla_drain_if #(
  parameter int unsigned DBITS = 16
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic             adr;
  logic [DBITS-1:0] dat;
  logic             ack;

  modport master (
    output cyc,
    output stb,
    output we,
    output adr,
    input  dat,
    input  ack
  );

  modport slave (
    input  cyc,
    input  stb,
    input  we,
    input  adr,
    output dat,
    output ack
  );
endinterface

// File: rtl/myla_drain.sv
// Wishbone initiator that drains the logic-analyzer capture queue onto a valid/ready stream.
// Optional bus timeout with sticky ERR_O is enabled by defining MYLA_DRAIN_TIMEOUT_EN.
module myla_drain #(
  parameter int unsigned DBITS    = 16,
  parameter int unsigned CBITS    = 16,
  parameter int unsigned POLL_DLY = 15,
  parameter logic        STAT_ADR = 1'b0,
  parameter logic        DATA_ADR = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             CLK_I,
  input  logic             RES_I,
  input  logic             EN_I,
  myla_drain_if.master     bus,
  output logic [DBITS-1:0] SMP_O,
  output logic             SMP_VALID_O,
  input  logic             SMP_READY_I,
  output logic             OVF_O,
  output logic [CBITS-1:0] CNT_O,
  output logic             ERR_O
);

  // Status bits need DAT_I[1:0]; a zero timeout would abort every access.
  if (DBITS < 2 || CBITS == 0 || TIMEOUT == 0) begin : g_param_err
    $error("myla_drain: DBITS must be >= 2, CBITS and TIMEOUT must be non-zero");
  end

  localparam int unsigned PW = (POLL_DLY < 2) ? 1 : $clog2(POLL_DLY + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStat,
    StWait,
    StRead,
    StPop,
    StOut
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic [DBITS-1:0] smp_q, smp_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic             adr_q, adr_d;
  logic             valid_q, valid_d;
  logic             bus_st;

`ifdef MYLA_DRAIN_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`endif

  assign bus_st = (state_q == StStat) || (state_q == StRead) || (state_q == StPop);

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (EN_I) state_d = StStat;
      end
      StStat: begin
        if (bus.ack) begin
          if (bus.dat[1]) ovf_d = 1'b1;
          if (!EN_I) begin
            state_d = StIdle;
          end else if (bus.dat[0]) begin
            state_d = StWait;
            poll_d  = PW'(POLL_DLY);
          end else begin
            state_d = StRead;
          end
        end
      end
      StWait: begin
        // Back-off lasts POLL_DLY cycles, never fewer than one.
        if (poll_q <= PW'(1)) begin
          state_d = EN_I ? StStat : StIdle;
          poll_d  = '0;
        end else begin
          poll_d = poll_q - PW'(1);
        end
      end
      StRead: begin
        if (bus.ack) begin
          smp_d   = bus.dat;
          state_d = StPop;
        end
      end
      StPop: begin
        if (bus.ack) state_d = StOut;
      end
      StOut: begin
        if (SMP_READY_I) begin
          cnt_d   = cnt_q + CBITS'(1);
          state_d = EN_I ? StStat : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MYLA_DRAIN_TIMEOUT_EN
    err_d = err_q;
    to_d  = to_q;
    if (bus_st && !bus.ack) begin
      if (to_q == TW'(TIMEOUT)) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
    if (state_d != state_q) to_d = '0;
`endif

    // Bus qualifiers follow the next state so they are valid for the whole access.
    cyc_d   = (state_d == StStat) || (state_d == StRead) || (state_d == StPop);
    we_d    = (state_d == StPop);
    adr_d   = ((state_d == StRead) || (state_d == StPop)) ? DATA_ADR : STAT_ADR;
    valid_d = (state_d == StOut);
  end

  always_ff @(posedge CLK_I or posedge RES_I) begin
    if (RES_I) begin
      state_q <= StIdle;
      poll_q  <= '0;
      smp_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
    end
  end

`ifdef MYLA_DRAIN_TIMEOUT_EN
  always_ff @(posedge CLK_I or posedge RES_I) begin
    if (RES_I) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign ERR_O = err_q;
`else
  assign ERR_O = 1'b0;
`endif

  // The responder's ack is registered, so masking the strobe with it gives one ack per request.
  assign bus.cyc = cyc_q;
  assign bus.stb = cyc_q & ~bus.ack;
  assign bus.we  = we_q;
  assign bus.adr = adr_q;

  assign SMP_O       = smp_q;
  assign SMP_VALID_O = valid_q;
  assign OVF_O       = ovf_q;
  assign CNT_O       = cnt_q;

endmodule

// File: tb/tb_myla_drain.sv
// Directed bench for myla_drain: registered-ack queue responder, stream sink, per-scenario tasks.
// Build with MYLA_DRAIN_TIMEOUT_EN defined to also exercise the bus timeout.
module tb_myla_drain;
  localparam int unsigned DBITS = 16;
  localparam int unsigned CBITS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic ready = 1'b0;

  logic [DBITS-1:0] smp;
  logic             valid;
  logic             ovf;
  logic [CBITS-1:0] cnt;
  logic             err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  myla_drain_if #(.DBITS(DBITS)) bus ();

  myla_drain #(
    .DBITS    (DBITS),
    .CBITS    (CBITS),
    .POLL_DLY (15),
    .STAT_ADR (1'b0),
    .DATA_ADR (1'b1),
    .TIMEOUT  (255)
  ) dut (
    .CLK_I       (clk),
    .RES_I       (rst),
    .EN_I        (en),
    .bus         (bus),
    .SMP_O       (smp),
    .SMP_VALID_O (valid),
    .SMP_READY_I (ready),
    .OVF_O       (ovf),
    .CNT_O       (cnt),
    .ERR_O       (err)
  );

  // Responder: sample queue behind a status/data register pair, ack one cycle after strobe.
  logic [15:0] q[$];
  logic [15:0] got[$];
  int          hs_t[$];
  bit          full_once = 0;
  bit          no_ack = 0;
  bit          seen_valid = 0;
  logic        ack_q;
  logic        pend_pop, pend_read, pend_stat;
  logic [15:0] stat_r = 16'h0001;
  logic [15:0] head_r = 16'hDEAD;
  int          n_pop = 0;
  int          n_read = 0;
  int          n_stat = 0;
  int          cyc_n = 0;

  function automatic void refresh();
    stat_r = full_once ? 16'h0002 : ((q.size() == 0) ? 16'h0001 : 16'h0000);
    head_r = (q.size() != 0) ? q[0] : 16'hDEAD;
  endfunction

  assign bus.ack = ack_q;
  assign bus.dat = bus.adr ? head_r : stat_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      pend_pop  <= 1'b0;
      pend_read <= 1'b0;
      pend_stat <= 1'b0;
    end else begin
      ack_q     <= bus.cyc && bus.stb && !no_ack;
      pend_pop  <= ack_q && bus.cyc && bus.we;
      pend_read <= ack_q && bus.cyc && !bus.we && bus.adr;
      pend_stat <= ack_q && bus.cyc && !bus.adr;
    end
  end

  always @(negedge clk) begin
    if (pend_pop) begin
      if (q.size() > 0) void'(q.pop_front());
      n_pop++;
    end
    if (pend_read) n_read++;
    if (pend_stat) begin
      n_stat++;
      full_once = 0;
    end
    if (valid) seen_valid = 1;
    refresh();
  end

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!rst && valid && ready) begin
      got.push_back(smp);
      hs_t.push_back(cyc_n);
    end
  end

  task automatic test_reset();
    en = 0;
    ready = 0;
    #2 rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cyc, bus.stb, bus.we, bus.adr, valid, ovf, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got cyc/stb/we/adr/valid/ovf/err=%b exp=0000000",
               {bus.cyc, bus.stb, bus.we, bus.adr, valid, ovf, err});
    end
    checks++;
    if (smp !== 16'h0000) begin
      failures++;
      $display("FAIL reset_smp got=%h exp=0000", smp);
    end
    checks++;
    if (cnt !== 16'h0000) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", cnt);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_empty_poll();
    int gap = -1;
    bit ok = 0;
    n_read = 0;
    n_stat = 0;
    seen_valid = 0;
    en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cyc) begin ok = 1; break; end
    end
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus.cyc) begin ok = 1; break; end
      end
    end
    if (ok) begin
      gap = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.cyc) break;
        gap++;
      end
    end
    checks++;
    if (gap != 15) begin
      failures++;
      $display("FAIL poll_gap got=%0d exp=15", gap);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (n_read != 0 || n_stat < 3) begin
      failures++;
      $display("FAIL poll_reads got reads=%0d stats=%0d exp reads=0 stats>=3", n_read, n_stat);
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("FAIL poll_valid got=1 exp=0");
    end
  endtask

  task automatic test_two_samples();
    @(negedge clk);
    #1;
    got.delete();
    hs_t.delete();
    n_pop = 0;
    ready = 1;
    q.push_back(16'h00A5);
    q.push_back(16'h5A00);
    refresh();
    for (int i = 0; i < 100 && got.size() < 2; i++) @(negedge clk);
    checks++;
    if (got.size() != 2) begin
      failures++;
      $display("FAIL two_count got=%0d exp=2", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'h00A5) begin
        failures++;
        $display("FAIL two_first got=%h exp=00a5", got[0]);
      end
      checks++;
      if (got[1] !== 16'h5A00) begin
        failures++;
        $display("FAIL two_second got=%h exp=5a00", got[1]);
      end
      checks++;
      if (hs_t[1] - hs_t[0] != 7) begin
        failures++;
        $display("FAIL two_rate got=%0d exp=7", hs_t[1] - hs_t[0]);
      end
    end
    checks++;
    if (cnt !== 16'd2 || n_pop != 2) begin
      failures++;
      $display("FAIL two_cnt_pops got cnt=%0d pops=%0d exp cnt=2 pops=2", cnt, n_pop);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bit ok = 0;
    @(negedge clk);
    #1;
    ready = 0;
    q.push_back(16'h1234);
    refresh();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid) begin ok = 1; break; end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (smp !== 16'h1234 || valid !== 1'b1 || bus.cyc !== 1'b0 || cnt !== 16'd2) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL bp_hold got seen_valid=%0d bad_cycles=%0d exp seen_valid=1 bad_cycles=0",
               ok, bad);
    end
    ready = 1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_valid got=%b exp=0", valid);
    end
    checks++;
    if (cnt !== 16'd3) begin
      failures++;
      $display("FAIL bp_release_cnt got=%0d exp=3", cnt);
    end
  endtask

  task automatic test_overflow();
    bit ok = 0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_initial got=%b exp=0", ovf);
    end
    @(negedge clk);
    #1;
    got.delete();
    q.push_back(16'h0BEE);
    full_once = 1;
    refresh();
    for (int i = 0; i < 80 && got.size() < 1; i++) @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || got.size() != 1 || cnt !== 16'd4) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b delivered=%0d cnt=%0d exp ovf=1 delivered=1 cnt=4",
               ovf, got.size(), cnt);
    end else begin
      checks++;
      if (got[0] !== 16'h0BEE) begin
        failures++;
        $display("FAIL ovf_sample got=%h exp=0bee", got[0]);
      end
    end
    repeat (40) @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", ovf);
    end
    #1;
    q.push_back(16'h7777);
    refresh();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cyc && bus.adr && !bus.we) begin ok = 1; break; end
    end
    rst = 1;
    en = 0;
    #1;
    checks++;
    if (!ok || bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_read got in_read=%0d cyc=%b stb=%b exp in_read=1 cyc=0 stb=0",
               ok, bus.cyc, bus.stb);
    end
    checks++;
    if (ovf !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_clears got ovf=%b cnt=%0d exp ovf=0 cnt=0", ovf, cnt);
    end
    @(negedge clk);
    rst = 0;
    q.delete();
    refresh();
  endtask

  task automatic test_en_drop();
    int busy = 0;
    bit ok = 0;
    @(negedge clk);
    #1;
    got.delete();
    q.push_back(16'h3C3C);
    refresh();
    ready = 1;
    en = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cyc && bus.adr && !bus.we) begin ok = 1; break; end
    end
    en = 0;
    for (int i = 0; i < 20 && got.size() < 1; i++) @(negedge clk);
    checks++;
    if (!ok || got.size() != 1 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL endrop_done got in_read=%0d delivered=%0d cnt=%0d exp 1/1/1",
               ok, got.size(), cnt);
    end else begin
      checks++;
      if (got[0] !== 16'h3C3C) begin
        failures++;
        $display("FAIL endrop_sample got=%h exp=3c3c", got[0]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.cyc || valid) busy++;
    end
    checks++;
    if (busy != 0) begin
      failures++;
      $display("FAIL endrop_idle got busy_cycles=%0d exp=0", busy);
    end
  endtask

`ifdef MYLA_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    bit ok = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    no_ack = 1;
    en = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cyc) begin ok = 1; break; end
    end
    while (ok && bus.cyc && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    en = 0;
    checks++;
    if (!ok || hi < 255 || hi > 256) begin
      failures++;
      $display("FAIL tmo_len got=%0d exp=255..256", hi);
    end
    checks++;
    if (err !== 1'b1 || bus.cyc !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err got err=%b cyc=%b exp err=1 cyc=0", err, bus.cyc);
    end
    @(negedge clk);
    checks++;
    if (bus.cyc !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_idle got cyc=%b err=%b exp cyc=0 err=1", bus.cyc, err);
    end
    no_ack = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_empty_poll();
    test_two_samples();
    test_backpressure();
    test_overflow();
    test_en_drop();
`ifdef MYLA_DRAIN_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
